// File: rtl/ram_port_ctrl_pkg.sv
// Shared types and constants for the RAM port controller.
// The request bundle is sized for the widest supported port; callers zero-extend.
package ram_port_ctrl_pkg;

  localparam int RD_LAT     = 2;
  localparam int REQ_AW_MAX = 32;
  localparam int REQ_DW_MAX = 64;

  typedef struct packed {
    logic                  wr;
    logic [REQ_AW_MAX-1:0] addr;
    logic [REQ_DW_MAX-1:0] data;
  } req_t;

  function automatic req_t pack_req(input logic                  wr,
                                    input logic [REQ_AW_MAX-1:0] addr,
                                    input logic [REQ_DW_MAX-1:0] data);
    req_t r;
    r.wr   = wr;
    r.addr = addr;
    r.data = data;
    return r;
  endfunction

endpackage

// File: rtl/ram_port_ctrl_if.sv
// Request/response handshake bundle between a client (master) and the controller (slave).
interface ram_port_ctrl_if #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 8
);

  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [AWIDTH-1:0] req_addr;
  logic [DWIDTH-1:0] req_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DWIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_wr, req_addr, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/ram_port_ctrl_rsp_fifo.sv
// Read-response buffer: power-of-two depth, head word held in a register.
// A push into a full buffer is dropped; the controller's credit count prevents it.
module rsp_fifo #(
  parameter int DWIDTH    = 8,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  output logic [DWIDTH-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);

  logic [DWIDTH-1:0] store [RSP_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     rd_nxt;
  logic [CW-1:0]     count;
  logic [DWIDTH-1:0] head_q;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign rd_nxt   = rd_ptr + PW'(1);
  assign pop_data = head_q;

  always_ff @(posedge clock) begin
    if (do_push) begin
      store[wr_ptr] <= push_data;
    end
  end

  // Head register reloads only when the head word changes, so it holds under stall.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_nxt;
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (!do_push && do_pop) begin
        count <= count - CW'(1);
      end
      if (do_push && (empty || (do_pop && count == CW'(1)))) begin
        head_q <= push_data;
      end else if (do_pop && count > CW'(1)) begin
        head_q <= store[rd_nxt];
      end
    end
  end

endmodule

// File: rtl/ram_port_ctrl.sv
// Single-port RAM front end: in-order read responses, credit-limited acceptance.
// Reads return no sooner than 3 cycles after fire; requests stall while occupancy is full.
module ram_port_ctrl
  import ram_port_ctrl_pkg::*;
#(
  parameter int DWIDTH    = 8,
  parameter int AWIDTH    = 8,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  ram_port_ctrl_if.slave    bus,
  output logic [AWIDTH-1:0] mem_address,
  output logic [DWIDTH-1:0] mem_wr_data,
  output logic              mem_wr_en,
  output logic              mem_en,
  input  logic [DWIDTH-1:0] mem_q
);

  localparam int OCC_W = $clog2(RSP_DEPTH + 1);
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(RSP_DEPTH);

  req_t              req;
  logic              fire;
  logic              rd_fire;
  logic              pop;
  logic [OCC_W-1:0]  occ;
  logic [OCC_W-1:0]  occ_next;
  logic              ready_q;
  logic              en_q;
  logic [RD_LAT-1:0] rd_tag;
  logic              fifo_full;
  logic              fifo_empty;
  logic              unused_bits;

  assign req = pack_req(bus.req_wr, REQ_AW_MAX'(bus.req_addr), REQ_DW_MAX'(bus.req_data));

  assign fire    = bus.req_valid & ready_q;
  assign rd_fire = fire & ~req.wr;
  assign pop     = bus.rsp_ready & ~fifo_empty;

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = ~fifo_empty;
  assign mem_address   = req.addr[AWIDTH-1:0];
  assign mem_wr_data   = req.data[DWIDTH-1:0];
  assign mem_wr_en     = fire & req.wr;
  assign mem_en        = en_q;
  assign unused_bits   = ^{req, fifo_full};

  // Occupancy covers reads still in the RAM pipeline as well as buffered words.
  always_comb begin
    occ_next = occ;
    if (rd_fire && !pop) begin
      occ_next = occ + OCC_W'(1);
    end else if (!rd_fire && pop) begin
      occ_next = occ - OCC_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      occ     <= '0;
      ready_q <= 1'b0;
      en_q    <= 1'b0;
      rd_tag  <= '0;
    end else begin
      occ     <= occ_next;
      ready_q <= (occ_next < DEPTH_C);
      en_q    <= fire;
      rd_tag  <= {rd_tag[RD_LAT-2:0], rd_fire};
    end
  end

  rsp_fifo #(
    .DWIDTH    (DWIDTH),
    .RSP_DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (rd_tag[RD_LAT-1]),
    .push_data (mem_q),
    .pop       (pop),
    .pop_data  (bus.rsp_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
